// File: rtl/ro_measure_ctrl.sv
// Ring-oscillator measurement sequencer: clear counter, gate one window, settle, latch, stream bytes.
// Build option RO_SYNC_HDR_EN prefixes every frame with a 0xA5 sync byte.
module ro_measure_ctrl #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             cont_i,
    output logic             window_en_o,
    input  logic             window_done_i,
    output logic             ro_clr_o,
    output logic             ro_cnt_en_o,
    input  logic [CNT_W-1:0] ro_count_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic             busy_o,
    output logic             meas_done_o
);

    localparam int unsigned NBYTES = CNT_W / 8;
`ifdef RO_SYNC_HDR_EN
    localparam int unsigned HDR_W     = 8;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
`else
    localparam int unsigned HDR_W     = 0;
`endif
    localparam int unsigned FRAME_BYTES = NBYTES + HDR_W / 8;
    localparam int unsigned SH_W        = CNT_W + HDR_W;
    localparam int unsigned BC_W        = $clog2(FRAME_BYTES + 1);
    localparam int unsigned SC_W        = $clog2(SETTLE_CYC + 1);
    localparam logic [BC_W-1:0] LAST_BYTE   = BC_W'(FRAME_BYTES - 1);
    localparam logic [SC_W-1:0] LAST_SETTLE = SC_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_MEASURE = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_LATCH   = 3'd4,
        ST_SEND    = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [SH_W-1:0]   shift_q, shift_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [SC_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic              window_en_q, window_en_d;
    logic              ro_clr_q, ro_clr_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic              meas_done_q, meas_done_d;
    logic [SH_W-1:0]   frame_load_c;

`ifdef RO_SYNC_HDR_EN
    assign frame_load_c = {SYNC_BYTE, ro_count_i};
`else
    assign frame_load_c = ro_count_i;
`endif

    // Next-state logic; every output is the registered image of the state being entered.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        settle_cnt_d = settle_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i || cont_i) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (window_done_i) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == LAST_SETTLE) begin
                    state_d = ST_LATCH;
                end else begin
                    settle_cnt_d = settle_cnt_q + SC_W'(1);
                end
            end
            ST_LATCH: begin
                shift_d    = frame_load_c;
                byte_cnt_d = '0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                // Shift only on handshake so tx_data holds while the UART stalls.
                if (tx_valid_q && tx_ready_i) begin
                    shift_d = shift_q << 8;
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = ST_DONE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = cont_i ? ST_CLEAR : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        window_en_d = (state_d == ST_MEASURE);
        ro_clr_d    = (state_d == ST_CLEAR);
        tx_valid_d  = (state_d == ST_SEND);
        busy_d      = (state_d != ST_IDLE);
        meas_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            settle_cnt_q <= '0;
            window_en_q  <= 1'b0;
            ro_clr_q     <= 1'b0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            meas_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            window_en_q  <= window_en_d;
            ro_clr_q     <= ro_clr_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            meas_done_q  <= meas_done_d;
        end
    end

    // Counter gate tracks the window enable exactly.
    assign window_en_o = window_en_q;
    assign ro_cnt_en_o = window_en_q;
    assign ro_clr_o    = ro_clr_q;
    assign tx_valid_o  = tx_valid_q;
    assign tx_data_o   = shift_q[SH_W-1 -: 8];
    assign busy_o      = busy_q;
    assign meas_done_o = meas_done_q;

endmodule
